// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S frame scheduler.
package i2s_pkg;

   localparam int I2S_DEFAULT_DW = 24;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_L = 2'd1,
      WAIT_R = 2'd2,
      FULL   = 2'd3
   } i2s_sched_state_t;

endpackage

// File: rtl/i2s_frame_sched_if.sv
// Sample-stream handshake between an audio source and the I2S frame scheduler.
interface i2s_frame_sched_if #(
   parameter int DW = i2s_pkg::I2S_DEFAULT_DW
);
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/i2s_frame_sched.sv
// Prefetches one left/right pair from the sample stream and hands it to the serializer on each frame strobe.
// Optional underrun counter port/logic is built when I2S_SCHED_UNDERRUN_CNT_EN is defined.
//
// state  | meaning
// IDLE   | scheduler disabled, strobes ignored, stream stalled
// WAIT_L | expecting the left word of the next pair
// WAIT_R | left word held, expecting the right word
// FULL   | complete pair held, waiting for the frame strobe
module i2s_frame_sched
   import i2s_pkg::*;
#(
   parameter int DW            = I2S_DEFAULT_DW,
   parameter int UNDERRUN_HOLD = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               frame_strobe,
   i2s_frame_sched_if.slave   stream,
   output logic [DW-1:0]      tx_left,
   output logic [DW-1:0]      tx_right,
   output logic               tx_load,
   output logic               underrun
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
   ,
   output logic [15:0]        underrun_cnt
`endif
);

   i2s_sched_state_t state, state_nxt;
   logic [DW-1:0]    pend_l, pend_r;
   logic [DW-1:0]    load_l, load_r;
   logic             accept, do_load, do_under;
   logic             pend_l_we, pend_r_we;

   assign stream.s_ready = en && ((state == WAIT_L) || (state == WAIT_R));
   assign accept         = stream.s_ready && stream.s_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_load   = 1'b0;
      do_under  = 1'b0;
      load_l    = pend_l;
      load_r    = pend_r;
      pend_l_we = 1'b0;
      pend_r_we = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = WAIT_L;
            WAIT_L: begin
               // a left word arriving with the strobe is dropped with the frame
               if (frame_strobe) begin
                  do_under  = 1'b1;
                  state_nxt = WAIT_L;
               end else if (accept) begin
                  pend_l_we = 1'b1;
                  state_nxt = WAIT_R;
               end
            end
            WAIT_R: begin
               if (frame_strobe) begin
                  state_nxt = WAIT_L;
                  if (accept) begin
                     do_load = 1'b1;
                     load_r  = stream.s_data;
                  end else begin
                     do_under = 1'b1;
                  end
               end else if (accept) begin
                  pend_r_we = 1'b1;
                  state_nxt = FULL;
               end
            end
            FULL: begin
               if (frame_strobe) begin
                  do_load   = 1'b1;
                  state_nxt = WAIT_L;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_l   <= '0;
         pend_r   <= '0;
         tx_left  <= '0;
         tx_right <= '0;
         tx_load  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         tx_load  <= do_load || do_under;
         underrun <= do_under;
         if (pend_l_we) pend_l <= stream.s_data;
         if (pend_r_we) pend_r <= stream.s_data;
         if (do_load) begin
            tx_left  <= load_l;
            tx_right <= load_r;
         end else if (do_under && (UNDERRUN_HOLD == 0)) begin
            tx_left  <= '0;
            tx_right <= '0;
         end
      end
   end

`ifdef I2S_SCHED_UNDERRUN_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        underrun_cnt <= '0;
      else if (!en)                                   underrun_cnt <= '0;
      else if (do_under && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif

endmodule

// File: doc/i2s_frame_sched.md
I2S_FRAME_SCHED -- requirements
Module: i2s_frame_sched

Interface
REQ-001 SHALL have parameter DW, default 24, meaning sample width in bits.
REQ-002 SHALL have parameter UNDERRUN_HOLD, default 0, meaning underrun policy: 0 outputs zeros, 1 repeats the last pair.
REQ-003 SHALL have port clk  input  1  system clock (MCLK domain).
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  scheduler enable.
REQ-006 SHALL have port frame_strobe  input  1  one-cycle pre-fetch pulse from the I2S clock generator (rd_early).
REQ-007 SHALL have port s_data  input  DW  sample stream data; words strictly alternate left, right.
REQ-008 SHALL have port s_valid  input  1  stream word valid.
REQ-009 SHALL have port s_ready  output  1  stream word accepted when s_valid && s_ready.
REQ-010 SHALL have port tx_left  output  DW  left sample to the serializer.
REQ-011 SHALL have port tx_right  output  DW  right sample to the serializer.
REQ-012 SHALL have port tx_load  output  1  one-cycle pulse: tx_left/tx_right updated.
REQ-013 SHALL have port underrun  output  1  one-cycle pulse: frame served without a complete pair.

Function
REQ-014 SHALL implement the states IDLE, WAIT_L, WAIT_R and FULL, holding one prefetched L/R pair.
REQ-015 SHALL assert s_ready combinationally iff en=1 and state is WAIT_L or WAIT_R; s_ready SHALL be 0 in FULL and IDLE.
REQ-016 SHALL move WAIT_L->WAIT_R on an accepted word, latching it as the pending left sample.
REQ-017 SHALL move WAIT_R->FULL on an accepted word, latching it as the pending right sample.
REQ-018 On frame_strobe in FULL: SHALL copy the pair to tx_left/tx_right, pulse tx_load the next cycle, and enter WAIT_L.
REQ-019 On frame_strobe in WAIT_R coincident with an accepted right word: SHALL bypass it, loading (pending left, s_data), pulse tx_load with no underrun, and enter WAIT_L.
REQ-020 On frame_strobe in WAIT_L, or in WAIT_R without an accepted word: SHALL pulse underrun and tx_load the next cycle, load zeros (UNDERRUN_HOLD=0) or keep tx_left/tx_right (UNDERRUN_HOLD=1), discard any pending left, and enter WAIT_L.
REQ-021 Latency from frame_strobe to tx_load, and to tx_left/tx_right updated, SHALL be exactly 1 cycle.
REQ-022 SHALL ignore frame_strobe in IDLE: no tx_load, no underrun.
REQ-023 en 1->0 SHALL enter IDLE next cycle and discard the pending pair; tx_left/tx_right SHALL hold.
REQ-024 en 0->1 SHALL enter WAIT_L.
REQ-025 Back-to-back strobes SHALL each be served independently under REQ-018..020.

Reset
REQ-026 Asserting rst SHALL asynchronously force: state IDLE, tx_left=0, tx_right=0, tx_load=0, underrun=0, pending pair cleared.
REQ-027 Reset mid-frame SHALL drop partial pairs; after release, the first accepted word is a left sample.

Configuration
REQ-028 With I2S_SCHED_UNDERRUN_CNT_EN defined: SHALL add output underrun_cnt [15:0], incrementing on each underrun pulse, saturating at 16'hFFFF, cleared by rst and while en=0.
REQ-029 Without I2S_SCHED_UNDERRUN_CNT_EN: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package i2s_pkg SHALL hold the state enum i2s_sched_state_t and the constant I2S_DEFAULT_DW=24.
REQ-031 Single module; no sub-module. The saturating counter SHALL be inline under the macro.

Verification
REQ-032 Stream 0x000111, 0x000222 with no backpressure, then frame_strobe -> next cycle tx_load=1, tx_left=0x000111, tx_right=0x000222, underrun=0.
REQ-033 frame_strobe with only 0x0000AA accepted, UNDERRUN_HOLD=0 -> underrun=1, tx_left=tx_right=0; next accepted word 0x0000BB is treated as left.
REQ-034 UNDERRUN_HOLD=1: after pair (0x5, 0x6) is loaded, frame_strobe with empty stream -> underrun=1, tx_load=1, outputs stay 0x5/0x6.
REQ-035 frame_strobe in the same cycle as an accepted right word 0x123456 (pending left 0x654321) -> tx_left=0x654321, tx_right=0x123456, underrun=0.
REQ-036 rst asserted asynchronously between clock edges while in FULL -> outputs 0 immediately, s_ready=0 until en=1 is sampled after release.
REQ-037 With macro: 70000 consecutive underruns -> underrun_cnt=0xFFFF; en=0 for one cycle -> underrun_cnt=0.
